// File: rtl/param_commit_sched.sv
// Double-buffered parameter scheduler: host triggers fill per-slot shadows, and the
// whole pending set commits atomically on a sim_clk rising edge. Optional readback via PARAM_READBACK_EN.
module param_commit_sched #(
  parameter int                  NSLOT     = 8,
  parameter int                  DW        = 32,
  parameter logic [NSLOT*DW-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NSLOT-1:0]      trig,
  input  logic [15:0]           wire_lo,
  input  logic [15:0]           wire_hi,
  input  logic                  sim_clk,
  input  logic                  freeze,
  output logic [NSLOT*DW-1:0]   param_bus,
  output logic [NSLOT-1:0]      pending,
  output logic                  commit_pls,
  output logic [7:0]            ovw_cnt
`ifdef PARAM_READBACK_EN
  ,
  input  logic [$clog2(NSLOT)-1:0] rb_sel,
  output logic [DW-1:0]            rb_data,
  output logic [1:0]               rb_pend
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic                sim_clk_d_r;
  logic [NSLOT*DW-1:0] shadow_r;
  logic [NSLOT*DW-1:0] active_r;
  logic [NSLOT-1:0]    pending_r;
  logic [NSLOT-1:0]    pend_nxt_s;
  logic [NSLOT-1:0]    ovw_mask_s;
  logic                commit_pls_r;
  logic [7:0]          ovw_cnt_r;
  logic                sim_edge_s;
  logic                commit_s;
  int unsigned         ovw_num_s;
  logic [DW-1:0]       host_word_s;

  // Saturating add keeps the overwrite counter pinned at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] base, input int unsigned inc);
    int unsigned sum;
    sum = int'(base) + inc;
    if (sum > 32'd255) begin
      return 8'hFF;
    end else begin
      return 8'(sum);
    end
  endfunction

  generate
    if (DW > 32) begin : g_wide
      assign host_word_s = {{(DW-32){1'b0}}, wire_hi, wire_lo};
    end else if (DW == 32) begin : g_exact
      assign host_word_s = {wire_hi, wire_lo};
    end else begin : g_narrow
      logic [31:0] full_word_s;
      assign full_word_s = {wire_hi, wire_lo};
      assign host_word_s = full_word_s[DW-1:0];
    end
  endgenerate

  // Commit decision, next pending set and overwrite tally.
  always_comb begin
    sim_edge_s = sim_clk & ~sim_clk_d_r;
    commit_s   = (state_r == ARMED) && sim_edge_s && !freeze;
    if (commit_s) begin
      // A trigger landing on the commit cycle re-arms its slot instead of counting as an overwrite.
      pend_nxt_s = trig;
      ovw_mask_s = '0;
    end else begin
      pend_nxt_s = pending_r | trig;
      ovw_mask_s = pending_r & trig;
    end
    ovw_num_s = 32'd0;
    for (int k = 0; k < NSLOT; k++) begin
      if (ovw_mask_s[k]) begin
        ovw_num_s = ovw_num_s + 32'd1;
      end else begin
        ovw_num_s = ovw_num_s;
      end
    end
  end

  // Scheduler state transitions.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (|trig) begin
          state_nxt_s = ARMED;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARMED: begin
        if (commit_s) begin
          state_nxt_s = COMMIT;
        end else begin
          state_nxt_s = ARMED;
        end
      end
      COMMIT: begin
        if (|pend_nxt_s) begin
          state_nxt_s = ARMED;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, shadow and active registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      sim_clk_d_r  <= 1'b0;
      shadow_r     <= RESET_VAL;
      active_r     <= RESET_VAL;
      pending_r    <= '0;
      commit_pls_r <= 1'b0;
      ovw_cnt_r    <= 8'h00;
    end else begin
      state_r      <= state_nxt_s;
      sim_clk_d_r  <= sim_clk;
      pending_r    <= pend_nxt_s;
      commit_pls_r <= commit_s;
      ovw_cnt_r    <= sat_add8(ovw_cnt_r, ovw_num_s);
      for (int k = 0; k < NSLOT; k++) begin
        if (commit_s && pending_r[k]) begin
          active_r[k*DW +: DW] <= shadow_r[k*DW +: DW];
        end
        if (trig[k]) begin
          shadow_r[k*DW +: DW] <= host_word_s;
        end
      end
    end
  end

  assign param_bus  = active_r;
  assign pending    = pending_r;
  assign commit_pls = commit_pls_r;
  assign ovw_cnt    = ovw_cnt_r;

`ifdef PARAM_READBACK_EN
  logic [DW-1:0] rb_data_r;

  // Registered shadow readback, one cycle behind rb_sel.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rb_data_r <= '0;
    end else begin
      rb_data_r <= shadow_r[int'(rb_sel)*DW +: DW];
    end
  end

  assign rb_data = rb_data_r;
  assign rb_pend = {pending_r[rb_sel], commit_pls_r};
`endif

endmodule

// File: tb/tb_param_commit_sched.sv
// Randomized self-checking bench for param_commit_sched against a slot-level reference model.
module tb_param_commit_sched;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [7:0]   trig;
  logic [15:0]  wire_lo;
  logic [15:0]  wire_hi;
  logic         sim_clk;
  logic         freeze;
  logic [255:0] param_bus;
  logic [7:0]   pending;
  logic         commit_pls;
  logic [7:0]   ovw_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state, one entry per slot.
  logic [31:0] m_sh  [8];
  logic [31:0] m_act [8];
  logic        m_pend[8];
  logic        m_cpls;
  int          m_ovw;
  logic        m_simd;

  param_commit_sched dut (
    .clk(clk), .reset_n(reset_n), .trig(trig), .wire_lo(wire_lo), .wire_hi(wire_hi),
    .sim_clk(sim_clk), .freeze(freeze), .param_bus(param_bus), .pending(pending),
    .commit_pls(commit_pls), .ovw_cnt(ovw_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Applies the spec rules to the inputs sampled at this clock edge.
  task automatic model_step();
    logic edge_seen, any_pend, commit, old;
    if (!reset_n) begin
      for (int k = 0; k < 8; k++) begin
        m_sh[k] = 32'h0; m_act[k] = 32'h0; m_pend[k] = 1'b0;
      end
      m_cpls = 1'b0; m_ovw = 0; m_simd = 1'b0;
    end else begin
      edge_seen = sim_clk && !m_simd;
      any_pend  = 1'b0;
      for (int k = 0; k < 8; k++) any_pend = any_pend | m_pend[k];
      commit = edge_seen && !freeze && any_pend;
      for (int k = 0; k < 8; k++) begin
        old = m_pend[k];
        if (commit && old) begin
          m_act[k]  = m_sh[k];
          m_pend[k] = 1'b0;
        end
        if (trig[k]) begin
          if (old && !commit && m_ovw < 255) m_ovw++;
          m_sh[k]   = {wire_hi, wire_lo};
          m_pend[k] = 1'b1;
        end
      end
      m_cpls = commit;
      m_simd = sim_clk;
    end
  endtask

  task automatic compare_all();
    logic [255:0] eb;
    logic [7:0]   ep;
    for (int k = 0; k < 8; k++) begin
      eb[k*32 +: 32] = m_act[k];
      ep[k] = m_pend[k];
    end
    check_val("param_bus", param_bus, eb);
    check_val("pending", 256'(pending), 256'(ep));
    check_val("commit_pls", 256'(commit_pls), 256'(m_cpls));
    check_val("ovw_cnt", 256'(ovw_cnt), 256'(m_ovw));
  endtask

  task automatic cyc(input logic [7:0] t, input logic [31:0] d, input logic sc,
                     input logic fz, input logic rn);
    @(negedge clk);
    trig = t; wire_hi = d[31:16]; wire_lo = d[15:0];
    sim_clk = sc; freeze = fz; reset_n = rn;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    logic sc;
    trig = 8'h00; wire_hi = 16'h0; wire_lo = 16'h0; sim_clk = 1'b0; freeze = 1'b0; reset_n = 1'b0;

    // Reset
    cyc(8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
    check_val("rst_bus", param_bus, 256'h0);
    check_val("rst_pend", 256'(pending), 256'h0);
    check_val("rst_ovw", 256'(ovw_cnt), 256'h0);
    check_val("rst_cpls", 256'(commit_pls), 256'h0);

    // Single slot load and commit
    cyc(8'h04, 32'h42A0_0000, 1'b0, 1'b0, 1'b1);
    cyc(8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    check_val("slot2_pend", 256'(pending), 256'h04);
    cyc(8'h00, 32'h0, 1'b1, 1'b0, 1'b1);
    check_val("slot2_val", 256'(param_bus[95:64]), 256'h42A0_0000);
    check_val("slot2_pls", 256'(commit_pls), 256'h1);
    check_val("slot2_others", 256'({param_bus[255:96], param_bus[63:0]}), 256'h0);
    cyc(8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    check_val("slot2_pls_once", 256'(commit_pls), 256'h0);

    // Overwrite before an edge
    cyc(8'h01, 32'h3F66_6666, 1'b0, 1'b0, 1'b1);
    cyc(8'h01, 32'h3F80_0000, 1'b0, 1'b0, 1'b1);
    check_val("ovw_one", 256'(ovw_cnt), 256'h1);
    cyc(8'h00, 32'h0, 1'b1, 1'b0, 1'b1);
    check_val("slot0_val", 256'(param_bus[31:0]), 256'h3F80_0000);

    // Freeze holds two edges, then release
    cyc(8'h03, 32'h1111_2222, 1'b0, 1'b1, 1'b1);
    cyc(8'h00, 32'h0, 1'b1, 1'b1, 1'b1);
    cyc(8'h00, 32'h0, 1'b0, 1'b1, 1'b1);
    cyc(8'h00, 32'h0, 1'b1, 1'b1, 1'b1);
    check_val("frz_pend", 256'(pending), 256'h03);
    check_val("frz_slot0", 256'(param_bus[31:0]), 256'h3F80_0000);
    cyc(8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(8'h00, 32'h0, 1'b1, 1'b0, 1'b1);
    check_val("frz_commit", 256'(param_bus[63:0]), 256'h1111_2222_1111_2222);
    check_val("frz_pend_clr", 256'(pending), 256'h0);

    // Trigger coinciding with commit of the same slot
    cyc(8'h02, 32'hAAAA_0001, 1'b0, 1'b0, 1'b1);
    cyc(8'h02, 32'hBBBB_0002, 1'b1, 1'b0, 1'b1);
    check_val("coin_old", 256'(param_bus[63:32]), 256'hAAAA_0001);
    check_val("coin_pend", 256'(pending), 256'h02);
    check_val("coin_ovw", 256'(ovw_cnt), 256'h1);
    cyc(8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(8'h00, 32'h0, 1'b1, 1'b0, 1'b1);
    check_val("coin_new", 256'(param_bus[63:32]), 256'hBBBB_0002);

    // Reset during the COMMIT cycle
    cyc(8'h10, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1);
    cyc(8'h00, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc(8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
    check_val("rstc_bus", param_bus, 256'h0);
    check_val("rstc_pend", 256'(pending), 256'h0);
    check_val("rstc_cpls", 256'(commit_pls), 256'h0);
    cyc(8'h00, 32'h0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic
    sc = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] t;
      logic       fz, rn;
      if ($urandom_range(0, 3) == 0) sc = ~sc;
      t  = ($urandom_range(0, 2) == 0) ? (8'($urandom) & 8'($urandom) & 8'($urandom)) : 8'h00;
      fz = ($urandom_range(0, 9) == 0);
      rn = ($urandom_range(0, 299) != 0);
      cyc(t, $urandom, sc, fz, rn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
